pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the 5-stage MIPS core. Replaces the fixed per-stage registers (DE/EM/MW style) with one block instantiated between any two stages. Adds:
- stall (hold) and flush (bubble) control;
- a valid bit;
- NDATA generic data channels;
- a configurable Tnew countdown;
- a forwarding-ready destination output.

---
 rtl/pipe_stage_reg_if.sv | 36 +++
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Bundle of stage-control, upstream and registered-output signals for pipe_stage_reg.
// master drives the stage inputs and observes the outputs; slave is the register itself.
interface pipe_stage_reg_if #(
  parameter int DW    = 32,
  parameter int NDATA = 2,
  parameter int A3W   = 5,
  parameter int TW    = 2
);
  logic                en;
  logic                flush;
  logic                in_valid;
  logic [DW-1:0]       in_instr;
  logic [DW-1:0]       in_pc;
  logic [NDATA*DW-1:0] in_data;
  logic [A3W-1:0]      in_a3;
  logic                in_rfwr;
  logic [TW-1:0]       in_tnew;
  logic                out_valid;
  logic [DW-1:0]       out_instr;
  logic [DW-1:0]       out_pc;
  logic [NDATA*DW-1:0] out_data;
  logic [A3W-1:0]      out_a3;
  logic                out_rfwr;
  logic [TW-1:0]       out_tnew;
  logic [A3W-1:0]      out_fwd_a3;

  modport master (
    output en, flush, in_valid, in_instr, in_pc, in_data, in_a3, in_rfwr, in_tnew,
    input  out_valid, out_instr, out_pc, out_data, out_a3, out_rfwr, out_tnew, out_fwd_a3
  );

  modport slave (
    input  en, flush, in_valid, in_instr, in_pc, in_data, in_a3, in_rfwr, in_tnew,
    output out_valid, out_instr, out_pc, out_data, out_a3, out_rfwr, out_tnew, out_fwd_a3
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall/flush, valid bit, Tnew countdown and forwarding tag.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int          DW      = 32,
  parameter int          NDATA   = 2,
  parameter int          A3W     = 5,
  parameter int          TW      = 2,
  parameter int          TDEC    = 1,
  parameter logic [31:0] INIT_PC = 32'h0000_3000
) (
  input  logic clk,
  input  logic reset,
  pipe_stage_reg_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  logic                valid_q, valid_d;
  logic [DW-1:0]       instr_q, instr_d;
  logic [DW-1:0]       pc_q, pc_d;
  logic [NDATA*DW-1:0] data_q, data_d;
  logic [A3W-1:0]      a3_q, a3_d;
  logic                rfwr_q, rfwr_d;
  logic [TW-1:0]       tnew_q, tnew_d;
  logic [TW-1:0]       tnew_load;
  logic                do_bubble;
  logic                do_hold;

  generate
    if (TDEC == 1) begin : g_tnew_dec
      // Saturate at zero instead of wrapping to all-ones.
      assign tnew_load = (bus.in_tnew == '0) ? '0 : bus.in_tnew - TW'(1);
    end else begin : g_tnew_pass
      assign tnew_load = bus.in_tnew;
    end
  endgenerate

  assign do_bubble = bus.flush | (bus.en & ~bus.in_valid);
  assign do_hold   = ~bus.flush & ~bus.en;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    data_d  = data_q;
    a3_d    = a3_q;
    rfwr_d  = rfwr_q;
    tnew_d  = tnew_q;
    if (do_bubble) begin
      // A bubble still carries the PC so exceptions can be attributed to it.
      valid_d = 1'b0;
      instr_d = '0;
      pc_d    = bus.in_pc;
      data_d  = '0;
      a3_d    = '0;
      rfwr_d  = 1'b0;
      tnew_d  = '0;
    end else if (bus.en) begin
      valid_d = 1'b1;
      instr_d = bus.in_instr;
      pc_d    = bus.in_pc;
      data_d  = bus.in_data;
      a3_d    = bus.in_a3;
      rfwr_d  = bus.in_rfwr;
      tnew_d  = tnew_load;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= DW'(INIT_PC);
      data_q  <= '0;
      a3_q    <= '0;
      rfwr_q  <= 1'b0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      a3_q    <= a3_d;
      rfwr_q  <= rfwr_d;
      tnew_q  <= tnew_d;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_instr  = instr_q;
  assign bus.out_pc     = pc_q;
  assign bus.out_data   = data_q;
  assign bus.out_a3     = a3_q;
  assign bus.out_rfwr   = rfwr_q;
  assign bus.out_tnew   = tnew_q;
  // Hazard unit must never match $0, bubbles or non-writing instructions.
  assign bus.out_fwd_a3 = (valid_q && rfwr_q && (a3_q != '0)) ? a3_q : '0;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (do_hold && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (do_bubble && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_stall_cnt  = stall_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: driver queues hand-computed results, monitor checks them.
// A second instance with TDEC=0 shares the stimulus to cover the pass-through Tnew path.
module tb_pipe_stage_reg;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pipe_stage_reg_if #(.DW(32), .NDATA(2), .A3W(5), .TW(2)) bus1 ();
  pipe_stage_reg_if #(.DW(32), .NDATA(2), .A3W(5), .TW(2)) bus0 ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall1, bubble1, stall0, bubble0;
`endif

  pipe_stage_reg #(.DW(32), .NDATA(2), .A3W(5), .TW(2), .TDEC(1), .INIT_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt  (stall1),
    .perf_bubble_cnt (bubble1)
`endif
  );

  pipe_stage_reg #(.DW(32), .NDATA(2), .A3W(5), .TW(2), .TDEC(0), .INIT_PC(32'h0000_3000)) dut_nodec (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .perf_stall_cnt  (stall0),
    .perf_bubble_cnt (bubble0)
`endif
  );

  assign bus0.en       = bus1.en;
  assign bus0.flush    = bus1.flush;
  assign bus0.in_valid = bus1.in_valid;
  assign bus0.in_instr = bus1.in_instr;
  assign bus0.in_pc    = bus1.in_pc;
  assign bus0.in_data  = bus1.in_data;
  assign bus0.in_a3    = bus1.in_a3;
  assign bus0.in_rfwr  = bus1.in_rfwr;
  assign bus0.in_tnew  = bus1.in_tnew;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [63:0] data;
    logic [4:0]  a3;
    logic        rf;
    logic [1:0]  tn;
    logic [1:0]  tn0;
    logic [4:0]  fwd;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [63:0] data_of(input logic [31:0] pc);
    return {pc ^ 32'hDEAD_0000, pc + 32'h0000_1111};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One stimulus edge plus the result expected right after it.
  task automatic vec(input logic en, input logic fl, input logic v, input logic [31:0] instr,
                     input logic [31:0] pc, input logic [4:0] a3, input logic rf, input logic [1:0] tn,
                     input logic e_v, input logic [31:0] e_instr, input logic [31:0] e_pc,
                     input logic [63:0] e_data, input logic [4:0] e_a3, input logic e_rf,
                     input logic [1:0] e_tn, input logic [1:0] e_tn0, input logic [4:0] e_fwd);
    exp_t e;
    @(negedge clk);
    bus1.en       = en;
    bus1.flush    = fl;
    bus1.in_valid = v;
    bus1.in_instr = instr;
    bus1.in_pc    = pc;
    bus1.in_data  = data_of(pc);
    bus1.in_a3    = a3;
    bus1.in_rfwr  = rf;
    bus1.in_tnew  = tn;
    e = '{v: e_v, instr: e_instr, pc: e_pc, data: e_data, a3: e_a3, rf: e_rf,
          tn: e_tn, tn0: e_tn0, fwd: e_fwd};
    exp_q.push_back(e);
  endtask

  // Monitor: the stage presents a new result after every edge that has a queued expectation.
  initial begin
    exp_t e;
    int   txn;
    txn = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("valid", 64'(bus1.out_valid), 64'(e.v));
        chk("instr", 64'(bus1.out_instr), 64'(e.instr));
        chk("pc", 64'(bus1.out_pc), 64'(e.pc));
        chk("data", bus1.out_data, e.data);
        chk("a3", 64'(bus1.out_a3), 64'(e.a3));
        chk("rfwr", 64'(bus1.out_rfwr), 64'(e.rf));
        chk("tnew", 64'(bus1.out_tnew), 64'(e.tn));
        chk("tnew_nodec", 64'(bus0.out_tnew), 64'(e.tn0));
        chk("fwd_a3", 64'(bus1.out_fwd_a3), 64'(e.fwd));
        $display("txn %0d: valid=%0d instr=%08h pc=%08h a3=%0d tnew=%0d fwd=%0d errors_so_far=%0d",
                 txn, bus1.out_valid, bus1.out_instr, bus1.out_pc, bus1.out_a3,
                 bus1.out_tnew, bus1.out_fwd_a3, n_errors);
        txn++;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    bus1.en = 1'b1; bus1.flush = 1'b0; bus1.in_valid = 1'b0;
    bus1.in_instr = '0; bus1.in_pc = '0; bus1.in_data = '0;
    bus1.in_a3 = '0; bus1.in_rfwr = 1'b0; bus1.in_tnew = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Non-zero state, then an asynchronous reset in mid-cycle.
    vec(1, 0, 1, 32'h0043_2021, 32'h0000_3000, 5'd4, 1, 2'd2,
        1, 32'h0043_2021, 32'h0000_3000, data_of(32'h0000_3000), 5'd4, 1, 2'd1, 2'd2, 5'd4);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("rst_valid", 64'(bus1.out_valid), 64'd0);
    chk("rst_instr", 64'(bus1.out_instr), 64'd0);
    chk("rst_pc", 64'(bus1.out_pc), 64'h0000_3000);
    chk("rst_data", bus1.out_data, 64'd0);
    chk("rst_a3", 64'(bus1.out_a3), 64'd0);
    chk("rst_rfwr", 64'(bus1.out_rfwr), 64'd0);
    chk("rst_tnew", 64'(bus1.out_tnew), 64'd0);
    chk("rst_fwd", 64'(bus1.out_fwd_a3), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    vec(1, 0, 1, 32'h8C08_0000, 32'h0000_3004, 5'd8, 1, 2'd1,
        1, 32'h8C08_0000, 32'h0000_3004, data_of(32'h0000_3004), 5'd8, 1, 2'd0, 2'd1, 5'd8);
    vec(1, 0, 1, 32'h0000_0000, 32'h0000_3008, 5'd0, 1, 2'd0,
        1, 32'h0000_0000, 32'h0000_3008, data_of(32'h0000_3008), 5'd0, 1, 2'd0, 2'd0, 5'd0);
    vec(1, 0, 1, 32'h0043_2021, 32'h0000_300C, 5'd4, 1, 2'd2,
        1, 32'h0043_2021, 32'h0000_300C, data_of(32'h0000_300C), 5'd4, 1, 2'd1, 2'd2, 5'd4);
    for (int i = 0; i < 3; i++) begin
      vec(0, 0, 1, 32'hFFFF_0000 + 32'(i), 32'h0000_4000 + 32'(4 * i), 5'd9, 1, 2'd3,
          1, 32'h0043_2021, 32'h0000_300C, data_of(32'h0000_300C), 5'd4, 1, 2'd1, 2'd2, 5'd4);
    end
    // Flush beats a stall; bubble keeps the incoming PC.
    vec(0, 1, 1, 32'h1111_2222, 32'h0000_3010, 5'd5, 1, 2'd3,
        0, 32'h0, 32'h0000_3010, 64'h0, 5'd0, 0, 2'd0, 2'd0, 5'd0);
    vec(1, 1, 1, 32'h3333_4444, 32'h0000_3014, 5'd6, 1, 2'd2,
        0, 32'h0, 32'h0000_3014, 64'h0, 5'd0, 0, 2'd0, 2'd0, 5'd0);
    vec(1, 0, 0, 32'h5555_6666, 32'h0000_3018, 5'd8, 1, 2'd2,
        0, 32'h0, 32'h0000_3018, 64'h0, 5'd0, 0, 2'd0, 2'd0, 5'd0);
    vec(1, 0, 1, 32'h1234_5678, 32'h0000_301C, 5'd8, 0, 2'd3,
        1, 32'h1234_5678, 32'h0000_301C, data_of(32'h0000_301C), 5'd8, 0, 2'd2, 2'd3, 5'd0);
    vec(0, 0, 0, 32'hAAAA_BBBB, 32'h0000_5000, 5'd7, 1, 2'd1,
        1, 32'h1234_5678, 32'h0000_301C, data_of(32'h0000_301C), 5'd8, 0, 2'd2, 2'd3, 5'd0);

    @(posedge clk);
    #2;
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_stall", 64'(stall1), 64'd4);
    chk("perf_bubble", 64'(bubble1), 64'd3);
`endif
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
